// File: rtl/i2s_fifo_player.sv
// rtl/i2s_fifo_player.sv - Drains the SDRAM read FIFO and serialises samples as an I2S slave DAC stream
module i2s_fifo_player #(
    parameter int DATA_W         = 16,
    parameter int LOAD_CYCLES    = 4,
    parameter int PRELOAD_FRAMES = 8,
    parameter int DRAIN_WORDS    = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              loop_en,
    input  logic              aud_bclk,
    input  logic              aud_lrck,
    output logic              aud_dacdat,
    output logic              rd_load,
    output logic              rdf_rdreq,
    input  logic [DATA_W-1:0] rdf_dout,
    input  logic              frame_read_done,
    output logic              busy
);
    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRELOAD, S_PLAY, S_DRAIN} state_t;
    state_t state, state_next;

    logic [2:0]        bclk_sync, lrck_sync, frd_sync;
    logic              bfall, lredge, lrrise, frd_rise;
    logic [8:0]        cnt;
    logic [4:0]        bit_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] hold;
    logic              rd_fire, rd_q, stop_pend, stopping, playing, playing_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            frd_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], aud_bclk};
            lrck_sync <= {lrck_sync[1:0], aud_lrck};
            frd_sync  <= {frd_sync[1:0], frame_read_done};
        end
    end

    assign bfall    = bclk_sync[2] & ~bclk_sync[1];
    assign lredge   = lrck_sync[2] ^ lrck_sync[1];
    assign lrrise   = ~lrck_sync[2] & lrck_sync[1];
    assign frd_rise = ~frd_sync[2] & frd_sync[1];

    assign stopping     = (state != S_IDLE) && (stop_pend || play_stop);
    assign playing      = (state == S_PLAY) || (state == S_DRAIN);
    assign playing_next = (state_next == S_PLAY) || (state_next == S_DRAIN);
    assign busy         = (state != S_IDLE);
    assign rd_load      = (state == S_LOAD);
    assign bit_idx      = IDX_W'(DATA_W - 1) - bit_cnt[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_fire    = 1'b0;
        case (state)
            S_IDLE:    if (play_start && !play_stop) state_next = S_LOAD;
            S_LOAD:    if (cnt == 9'(LOAD_CYCLES - 1)) state_next = S_PRELOAD;
            // The frame edge that ends preload is also the first channel edge of playback.
            S_PRELOAD: if (lrrise && cnt == 9'(PRELOAD_FRAMES - 1)) begin
                state_next = S_PLAY;
                rd_fire    = 1'b1;
            end
            S_PLAY: begin
                rd_fire = lredge;
                if (frd_rise && !loop_en) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                rd_fire = lredge && (cnt != '0);
                if (lrrise && cnt == '0) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (stopping) begin
            rd_fire = 1'b0;
            if (lrrise) state_next = S_IDLE;
        end
    end

    // cnt is shared: LOAD cycles, PRELOAD frames, DRAIN words remaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            stop_pend  <= 1'b0;
            rdf_rdreq  <= 1'b0;
            rd_q       <= 1'b0;
            hold       <= '0;
            bit_cnt    <= '0;
            aud_dacdat <= 1'b0;
        end else begin
            if (state_next != state)
                cnt <= (state_next == S_DRAIN) ? 9'(DRAIN_WORDS) : '0;
            else if (state == S_LOAD || (state == S_PRELOAD && lrrise))
                cnt <= cnt + 9'd1;
            else if (state == S_DRAIN && rd_fire)
                cnt <= cnt - 9'd1;

            if (state_next == S_IDLE) stop_pend <= 1'b0;
            else if (stopping)        stop_pend <= 1'b1;

            rdf_rdreq <= rd_fire;
            rd_q      <= rdf_rdreq;
            // A channel without a read (stop tail, drained) plays silence rather than a repeat.
            if (rd_q)                     hold <= rdf_dout;
            else if (lredge && !rd_fire)  hold <= '0;

            if (lredge)
                bit_cnt <= '0;
            else if (playing && bfall && bit_cnt < 5'(DATA_W))
                bit_cnt <= bit_cnt + 5'd1;

            if (!playing_next)
                aud_dacdat <= 1'b0;
            else if (playing && bfall && !lredge)
                aud_dacdat <= (bit_cnt < 5'(DATA_W)) && hold[bit_idx];
        end
    end
endmodule

// File: tb/tb_i2s_fifo_player.sv
// tb/tb_i2s_fifo_player.sv - Randomised bench: codec master, FIFO model and slot-level I2S reference
module tb_i2s_fifo_player;
    localparam int DRAIN_N = 20;
    localparam int FRAMES  = 10;
    localparam int HB      = 94;

    logic        clk, rst_n, play_start, play_stop, loop_en;
    logic        aud_bclk, aud_lrck, aud_dacdat, rd_load, rdf_rdreq, frame_read_done, busy;
    logic [15:0] rdf_dout;

    logic [15:0] words [0:511];
    int n_checks = 0, n_errors = 0;
    int half_cnt = 0, rd_count = 0, wide_cnt = 0;
    int play_half = 0, rd_base = 0;
    bit chk_ser = 0;

    i2s_fifo_player #(.DRAIN_WORDS(DRAIN_N)) dut (
        .clk(clk), .rst_n(rst_n), .play_start(play_start), .play_stop(play_stop),
        .loop_en(loop_en), .aud_bclk(aud_bclk), .aud_lrck(aud_lrck), .aud_dacdat(aud_dacdat),
        .rd_load(rd_load), .rdf_rdreq(rdf_rdreq), .rdf_dout(rdf_dout),
        .frame_read_done(frame_read_done), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #10 clk = ~clk;
    end

    // Codec master; each half-frame is captured as a 32-bit slot: delay bit, 16 data bits, pads.
    initial begin : codec
        logic [31:0] slot_bits;
        bit slot_live;
        int pos, s;
        aud_bclk = 0; aud_lrck = 0; slot_bits = '0; slot_live = 0;
        #1;
        forever begin
            for (int b = 0; b < 64; b++) begin
                #HB aud_bclk = 1;
                #HB;
                pos = b % 32;
                if (pos == 0) begin slot_bits = '0; slot_live = chk_ser; end
                slot_bits[31 - pos] = aud_dacdat;
                if (pos == 31 && slot_live && chk_ser) begin
                    s = half_cnt - play_half;
                    check("slot", slot_bits,
                          (s < 0) ? 32'h0 : {1'b0, words[(rd_base + s) % 512], 15'h0});
                end
                aud_bclk = 0;
                if (pos == 31) begin aud_lrck = ~aud_lrck; half_cnt++; end
            end
        end
    end

    initial begin : fifo_model
        bit prev;
        prev = 0;
        rdf_dout = '0;
        forever begin
            @(negedge clk);
            if (rdf_rdreq) begin
                if (prev) wide_cnt++;
                rdf_dout = words[rd_count % 512];
                rd_count++;
            end
            prev = rdf_rdreq;
        end
    end

    task automatic wait_half(input int target);
        int n;
        n = 0;
        while (half_cnt < target && n < 20000) begin @(posedge clk); n++; end
        if (half_cnt < target) check("wait_half_timeout", 32'(half_cnt), 32'(target));
    endtask

    task automatic wait_low_half();
        wait_half(half_cnt + 1);
        if (aud_lrck) wait_half(half_cnt + 1);
        repeat (20) @(posedge clk);
    endtask

    task automatic start_play();
        logic [7:0] v;
        wait_low_half();
        rd_base   = rd_count;
        play_half = half_cnt + 15;
        chk_ser   = 1;
        @(posedge clk); #1 play_start = 1;
        @(posedge clk); #1 play_start = 0;
        for (int i = 0; i < 8; i++) begin v[i] = rd_load; @(posedge clk); #1; end
        check("rd_load_pulse", 32'(v), 32'h0F);
        check("busy_after_start", 32'(busy), 1);
    endtask

    initial begin : main
        logic [31:0] acc;
        int snap, h0;
        rst_n = 0; play_start = 0; play_stop = 0; loop_en = 1; frame_read_done = 0;
        words[0] = 16'hA5C3;
        words[1] = 16'h1234;
        for (int i = 2; i < 512; i++) words[i] = 16'($urandom);

        repeat (20) @(posedge clk);
        #1 check("reset_outputs", 32'({aud_dacdat, rd_load, rdf_rdreq, busy}), 0);
        rst_n = 1;
        acc = 0;
        repeat (100) begin @(negedge clk); acc |= 32'({aud_dacdat, rd_load, rdf_rdreq, busy}); end
        check("idle_after_reset", acc, 0);

        start_play();
        wait_half(play_half);
        check("no_reads_in_preload", 32'(rd_count - rd_base), 0);
        repeat (10) @(posedge clk);
        check("first_read", 32'(rd_count - rd_base), 1);

        wait_half(play_half + 2);
        snap = rd_count;
        wait_half(play_half + 2 + 2 * FRAMES);
        check("reads_per_frames", 32'(rd_count - snap), 32'(2 * FRAMES));
        check("rdreq_one_cycle", 32'(wide_cnt), 0);

        wait_low_half();
        frame_read_done = 1; h0 = half_cnt; snap = rd_count;
        wait_half(h0 + 20);
        repeat (10) @(posedge clk);
        check("loop_reads", 32'(rd_count - snap), 20);
        check("loop_busy", 32'(busy), 1);

        frame_read_done = 0; loop_en = 0;
        wait_low_half();
        chk_ser = 0;
        frame_read_done = 1; h0 = half_cnt; snap = rd_count;
        wait_half(h0 + 21);
        check("drain_busy_until_rise", 32'(busy), 1);
        check("drain_reads_before_end", 32'(rd_count - snap), 32'(DRAIN_N));
        repeat (10) @(posedge clk);
        check("drain_idle", 32'(busy), 0);
        check("drain_read_total", 32'(rd_count - snap), 32'(DRAIN_N));
        check("drain_dac_quiet", 32'(aud_dacdat), 0);

        frame_read_done = 0;
        start_play();
        wait_half(play_half + 6);
        wait_low_half();
        chk_ser = 0;
        @(posedge clk); #1 play_stop = 1; h0 = half_cnt; snap = rd_count;
        @(posedge clk); #1 play_stop = 0;
        wait_half(h0 + 1);
        check("stop_busy_until_rise", 32'(busy), 1);
        repeat (10) @(posedge clk);
        check("stop_idle", 32'(busy), 0);
        check("stop_no_reads", 32'(rd_count - snap), 0);

        @(posedge clk); #1 play_start = 1; play_stop = 1;
        @(posedge clk); #1 play_start = 0; play_stop = 0;
        acc = 0;
        repeat (10) begin @(negedge clk); acc |= 32'({rd_load, busy}); end
        check("start_stop_same_cycle", acc, 0);

        @(posedge clk); #1 play_start = 1;
        @(posedge clk); #1 play_start = 0;
        check("load_before_reset", 32'(rd_load), 1);
        rst_n = 0;
        #1 check("async_reset_clears", 32'({aud_dacdat, rd_load, rdf_rdreq, busy}), 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1;
        repeat (5) @(posedge clk);
        check("rdreq_one_cycle_end", 32'(wide_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
